// File: rtl/control_sequencer.sv
// control_sequencer
//   Multi-cycle instruction sequencer. Owns the program counter, fetches one
//   instruction per ready/valid handshake, holds it in an instruction register
//   and drives one cycle of datapath strobes for the register file, the
//   accumulator and the ALU. Supports immediate load, jumps, a zero-conditional
//   jump and a terminal halt state.
//
// Ports
//   CLK          in   clock, rising edge active
//   RESET        in   asynchronous active-high reset
//   INSTRUCTION  in   {opcode[3:0], field[DATA_WIDTH-1:0]}
//   INSTR_VALID  in   INSTRUCTION valid for the address on PC
//   ZERO         in   ALU zero flag, used by JZ on the EXEC->FETCH edge
//   INSTR_READY  out  instruction accepted this cycle when VALID is high
//   PC           out  fetch address
//   SEL          out  accumulator input mux, 1 selects IMM
//   IMM          out  field of the held instruction
//   CE_R         out  one-hot register write enable
//   REG_IDX      out  register read index (field[REG_AW-1:0])
//   CE_ACC       out  accumulator write enable
//   OP           out  ALU operation
//   HALTED       out  sequencer is halted
module control_sequencer #(
  parameter int OP_WIDTH   = 4,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS   = 4,
  parameter int REG_AW     = 2,
  parameter int PC_WIDTH   = 8
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [DATA_WIDTH+3:0]   INSTRUCTION,
  input  logic                    INSTR_VALID,
  input  logic                    ZERO,
  output logic                    INSTR_READY,
  output logic [PC_WIDTH-1:0]     PC,
  output logic                    SEL,
  output logic [DATA_WIDTH-1:0]   IMM,
  output logic [NUM_REGS-1:0]     CE_R,
  output logic [REG_AW-1:0]       REG_IDX,
  output logic                    CE_ACC,
  output logic [OP_WIDTH-1:0]     OP,
  output logic                    HALTED
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [3:0] OPC_LD  = 4'hA;
  localparam logic [3:0] OPC_ST  = 4'hB;
  localparam logic [3:0] OPC_LDI = 4'hC;
  localparam logic [3:0] OPC_JMP = 4'hD;
  localparam logic [3:0] OPC_JZ  = 4'hE;
  localparam logic [3:0] OPC_HLT = 4'hF;

  localparam logic [OP_WIDTH-1:0] OP_PASS_ACC = OP_WIDTH'(4'hA);
  localparam logic [OP_WIDTH-1:0] OP_PASS_REG = OP_WIDTH'(4'hB);

  state_t                  state_q;
  logic [PC_WIDTH-1:0]     pc_q;
  logic [DATA_WIDTH+3:0]   ir_q;
  logic                    ready_q;
  logic                    halted_q;
  logic                    sel_q;
  logic [NUM_REGS-1:0]     ce_r_q;
  logic                    ce_acc_q;
  logic [OP_WIDTH-1:0]     op_q;

  logic [3:0]              opc_d;
  logic [REG_AW-1:0]       idx_d;
  logic                    dec_sel_d;
  logic                    dec_ce_acc_d;
  logic [OP_WIDTH-1:0]     dec_op_d;
  logic [NUM_REGS-1:0]     dec_ce_r_d;
  logic [3:0]              ir_opc_d;
  logic [PC_WIDTH-1:0]     target_d;

  // Decode the incoming instruction so the EXEC strobes can be registered
  // on the accepting edge; outputs never see INSTRUCTION combinationally.
  always_comb begin
    opc_d        = INSTRUCTION[DATA_WIDTH+3:DATA_WIDTH];
    idx_d        = INSTRUCTION[REG_AW-1:0];
    dec_sel_d    = 1'b0;
    dec_ce_acc_d = 1'b0;
    dec_op_d     = OP_PASS_ACC;
    dec_ce_r_d   = '0;
    case (opc_d)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4,
      4'h5, 4'h6, 4'h7, 4'h8, 4'h9: begin
        dec_ce_acc_d = 1'b1;
        dec_op_d     = OP_WIDTH'(opc_d);
      end
      OPC_LD: begin
        dec_ce_acc_d = 1'b1;
        dec_op_d     = OP_PASS_REG;
      end
      OPC_ST: begin
        // Out-of-range indices match no bit, turning the store into a no-op.
        for (int i = 0; i < NUM_REGS; i++) begin
          dec_ce_r_d[i] = (int'(idx_d) == i);
        end
      end
      OPC_LDI: begin
        dec_sel_d    = 1'b1;
        dec_ce_acc_d = 1'b1;
      end
      default: begin
        // JMP, JZ, HLT drive no datapath strobes.
        dec_sel_d    = 1'b0;
      end
    endcase
  end

  // Fields of the held instruction used during EXEC.
  always_comb begin
    ir_opc_d = ir_q[DATA_WIDTH+3:DATA_WIDTH];
    target_d = ir_q[PC_WIDTH-1:0];
  end

  // Sequencer FSM with registered handshake and strobe outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      ir_q     <= '0;
      ready_q  <= 1'b0;
      halted_q <= 1'b0;
      sel_q    <= 1'b0;
      ce_r_q   <= '0;
      ce_acc_q <= 1'b0;
      op_q     <= OP_PASS_ACC;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q <= S_FETCH;
          ready_q <= 1'b1;
        end
        S_FETCH: begin
          if (INSTR_VALID) begin
            ir_q     <= INSTRUCTION;
            pc_q     <= pc_q + PC_WIDTH'(1);
            state_q  <= S_EXEC;
            ready_q  <= 1'b0;
            sel_q    <= dec_sel_d;
            ce_r_q   <= dec_ce_r_d;
            ce_acc_q <= dec_ce_acc_d;
            op_q     <= dec_op_d;
          end
        end
        S_EXEC: begin
          // Strobes last exactly one cycle.
          sel_q    <= 1'b0;
          ce_r_q   <= '0;
          ce_acc_q <= 1'b0;
          op_q     <= OP_PASS_ACC;
          case (ir_opc_d)
            OPC_JMP: begin
              pc_q    <= target_d;
              state_q <= S_FETCH;
              ready_q <= 1'b1;
            end
            OPC_JZ: begin
              if (ZERO) begin
                pc_q <= target_d;
              end
              state_q <= S_FETCH;
              ready_q <= 1'b1;
            end
            OPC_HLT: begin
              state_q  <= S_HALT;
              halted_q <= 1'b1;
            end
            default: begin
              state_q <= S_FETCH;
              ready_q <= 1'b1;
            end
          endcase
        end
        S_HALT: begin
          // Terminal until reset.
          ready_q  <= 1'b0;
          halted_q <= 1'b1;
        end
        default: begin
          state_q  <= S_IDLE;
          ready_q  <= 1'b0;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign INSTR_READY = ready_q;
  assign PC          = pc_q;
  assign SEL         = sel_q;
  assign IMM         = ir_q[DATA_WIDTH-1:0];
  assign CE_R        = ce_r_q;
  assign REG_IDX     = ir_q[REG_AW-1:0];
  assign CE_ACC      = ce_acc_q;
  assign OP          = op_q;
  assign HALTED      = halted_q;

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  logic        CLK;
  logic        RESET;
  logic [11:0] INSTRUCTION;
  logic        INSTR_VALID;
  logic        ZERO;
  logic        INSTR_READY;
  logic [7:0]  PC;
  logic        SEL;
  logic [7:0]  IMM;
  logic [3:0]  CE_R;
  logic [1:0]  REG_IDX;
  logic        CE_ACC;
  logic [3:0]  OP;
  logic        HALTED;

  // second instance with three registers
  logic [11:0] instr3;
  logic        valid3;
  logic        zero3;
  logic        ready3;
  logic [7:0]  pc3;
  logic        sel3;
  logic [7:0]  imm3;
  logic [2:0]  ce_r3;
  logic [1:0]  reg_idx3;
  logic        ce_acc3;
  logic [3:0]  op3;
  logic        halted3;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic       sel;
    logic [3:0] ce_r;
    logic       ce_acc;
    logic [3:0] op;
    logic [7:0] imm;
    logic [1:0] reg_idx;
  } exp_t;

  exp_t       sb_q[$];
  logic [2:0] sb3_q[$];
  logic [7:0] pc_m;

  control_sequencer u_dut (
    .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION), .INSTR_VALID(INSTR_VALID),
    .ZERO(ZERO), .INSTR_READY(INSTR_READY), .PC(PC), .SEL(SEL), .IMM(IMM),
    .CE_R(CE_R), .REG_IDX(REG_IDX), .CE_ACC(CE_ACC), .OP(OP), .HALTED(HALTED)
  );

  control_sequencer #(.NUM_REGS(3)) u_dut3 (
    .CLK(CLK), .RESET(RESET), .INSTRUCTION(instr3), .INSTR_VALID(valid3),
    .ZERO(zero3), .INSTR_READY(ready3), .PC(pc3), .SEL(sel3), .IMM(imm3),
    .CE_R(ce_r3), .REG_IDX(reg_idx3), .CE_ACC(ce_acc3), .OP(op3), .HALTED(halted3)
  );

  always #5 CLK = ~CLK;

  function automatic exp_t model(input logic [11:0] ins);
    exp_t e;
    logic [3:0] opc;
    opc       = ins[11:8];
    e.sel     = 1'b0;
    e.ce_r    = 4'b0000;
    e.ce_acc  = 1'b0;
    e.op      = 4'hA;
    e.imm     = ins[7:0];
    e.reg_idx = ins[1:0];
    if (opc <= 4'h9) begin
      e.ce_acc = 1'b1;
      e.op     = opc;
    end else if (opc == 4'hA) begin
      e.ce_acc = 1'b1;
      e.op     = 4'hB;
    end else if (opc == 4'hB) begin
      e.ce_r = 4'b0001 << ins[1:0];
    end else if (opc == 4'hC) begin
      e.sel    = 1'b1;
      e.ce_acc = 1'b1;
    end
    return e;
  endfunction

  task automatic reset_dut();
    @(negedge CLK);
    RESET       = 1'b1;
    INSTR_VALID = 1'b0;
    valid3      = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    pc_m  = 8'h00;
    sb_q.delete();
    sb3_q.delete();
  endtask

  // Fetch one instruction, check its EXEC cycle and the following cycle.
  task automatic issue(input logic [11:0] ins, input logic zero_v, input string name);
    int   n;
    exp_t e;
    logic [3:0] opc;
    opc = ins[11:8];
    n   = 0;
    while (INSTR_READY !== 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    n_cmp++;
    if (INSTR_READY !== 1'b1) begin
      n_err++;
      $display("FAIL %s_ready_timeout: got %b want 1", name, INSTR_READY);
      return;
    end
    n_cmp++;
    if (PC !== pc_m) begin
      n_err++;
      $display("FAIL %s_fetch_pc: got %h want %h", name, PC, pc_m);
    end
    INSTRUCTION = ins;
    INSTR_VALID = 1'b1;
    ZERO        = ~zero_v;
    sb_q.push_back(model(ins));
    @(negedge CLK);
    INSTR_VALID = 1'b0;
    INSTRUCTION = 12'h000;
    ZERO        = zero_v;
    e = sb_q.pop_front();
    n_cmp++;
    if ({SEL, CE_R, CE_ACC, OP, IMM, REG_IDX} !== e) begin
      n_err++;
      $display("FAIL %s_exec_strobes: got sel=%b ce_r=%b ce_acc=%b op=%h imm=%h idx=%h want %h",
               name, SEL, CE_R, CE_ACC, OP, IMM, REG_IDX, e);
    end
    n_cmp++;
    if ({INSTR_READY, PC} !== {1'b0, pc_m + 8'h01}) begin
      n_err++;
      $display("FAIL %s_exec_pc: got rdy=%b pc=%h want rdy=0 pc=%h", name, INSTR_READY, PC, pc_m + 8'h01);
    end
    pc_m = pc_m + 8'h01;
    if (opc == 4'hD) pc_m = ins[7:0];
    if (opc == 4'hE && zero_v) pc_m = ins[7:0];
    @(negedge CLK);
    ZERO = 1'b0;
    n_cmp++;
    if (opc == 4'hF) begin
      if ({HALTED, INSTR_READY, CE_ACC, PC} !== {1'b1, 1'b0, 1'b0, pc_m}) begin
        n_err++;
        $display("FAIL %s_halt_entry: got h=%b rdy=%b ce=%b pc=%h", name, HALTED, INSTR_READY, CE_ACC, PC);
      end
    end else begin
      if ({INSTR_READY, SEL, CE_R, CE_ACC, OP, PC} !== {1'b1, 1'b0, 4'b0000, 1'b0, 4'hA, pc_m}) begin
        n_err++;
        $display("FAIL %s_post_exec: got rdy=%b sel=%b ce_r=%b ce=%b op=%h pc=%h want pc=%h",
                 name, INSTR_READY, SEL, CE_R, CE_ACC, OP, PC, pc_m);
      end
    end
  endtask

  task automatic test_reset();
    RESET       = 1'b1;
    INSTR_VALID = 1'b1;
    INSTRUCTION = 12'h501;
    repeat (2) @(negedge CLK);
    n_cmp++;
    if ({INSTR_READY, HALTED, SEL, CE_R, CE_ACC, OP, IMM, REG_IDX, PC} !==
        {1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'hA, 8'h00, 2'b00, 8'h00}) begin
      n_err++;
      $display("FAIL reset_values: rdy=%b h=%b sel=%b ce_r=%b ce=%b op=%h imm=%h idx=%h pc=%h",
               INSTR_READY, HALTED, SEL, CE_R, CE_ACC, OP, IMM, REG_IDX, PC);
    end
    RESET = 1'b0;
    pc_m  = 8'h00;
    n_cmp++;
    if (INSTR_READY !== 1'b0) begin
      n_err++;
      $display("FAIL idle_ready: got %b want 0", INSTR_READY);
    end
    @(negedge CLK);
    n_cmp++;
    if ({INSTR_READY, CE_ACC, PC} !== {1'b1, 1'b0, 8'h00}) begin
      n_err++;
      $display("FAIL first_fetch: got rdy=%b ce=%b pc=%h want 1 0 00", INSTR_READY, CE_ACC, PC);
    end
    issue(12'h501, 1'b0, "add_after_reset");
  endtask

  task automatic test_ldi_st();
    reset_dut();
    issue(12'hC5A, 1'b0, "ldi_5a");
    issue(12'hB02, 1'b0, "st_r2");
  endtask

  task automatic test_jz();
    reset_dut();
    for (int i = 0; i < 5; i++) issue(12'h900, 1'b0, "inc_pad");
    issue(12'hE40, 1'b0, "jz_not_taken");
    n_cmp++;
    if (PC !== 8'h06) begin
      n_err++;
      $display("FAIL jz_not_taken_pc: got %h want 06", PC);
    end
    issue(12'hD05, 1'b0, "jmp_05");
    issue(12'hE40, 1'b1, "jz_taken");
    n_cmp++;
    if (PC !== 8'h40) begin
      n_err++;
      $display("FAIL jz_taken_pc: got %h want 40", PC);
    end
  endtask

  task automatic test_wrap_stall();
    reset_dut();
    issue(12'hDFF, 1'b0, "jmp_ff");
    issue(12'h501, 1'b0, "add_at_ff");
    n_cmp++;
    if (PC !== 8'h00) begin
      n_err++;
      $display("FAIL pc_wrap: got %h want 00", PC);
    end
    INSTRUCTION = 12'h377;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      n_cmp++;
      if ({INSTR_READY, SEL, CE_R, CE_ACC, OP, PC} !== {1'b1, 1'b0, 4'b0000, 1'b0, 4'hA, 8'h00}) begin
        n_err++;
        $display("FAIL stall_cycle%0d: rdy=%b sel=%b ce_r=%b ce=%b op=%h pc=%h",
                 i, INSTR_READY, SEL, CE_R, CE_ACC, OP, PC);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] prog [8];
    prog = '{12'h000, 12'h1F1, 12'h2E2, 12'h3D3, 12'h6C0, 12'h7B0, 12'h8A0, 12'hA03};
    reset_dut();
    for (int i = 0; i < 8; i++) issue(prog[i], 1'b0, "b2b");
    issue(12'hB01, 1'b0, "st_r1");
    issue(12'hB03, 1'b0, "st_r3");
  endtask

  task automatic test_halt();
    reset_dut();
    issue(12'h402, 1'b0, "sub");
    issue(12'hF00, 1'b0, "hlt");
    INSTR_VALID = 1'b1;
    INSTRUCTION = 12'h501;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      n_cmp++;
      if ({HALTED, INSTR_READY, CE_ACC, PC} !== {1'b1, 1'b0, 1'b0, 8'h02}) begin
        n_err++;
        $display("FAIL halt_hold%0d: h=%b rdy=%b ce=%b pc=%h", i, HALTED, INSTR_READY, CE_ACC, PC);
      end
    end
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    INSTR_VALID = 1'b0;
    n_cmp++;
    if ({HALTED, INSTR_READY, PC} !== {1'b0, 1'b0, 8'h00}) begin
      n_err++;
      $display("FAIL halt_exit_reset: h=%b rdy=%b pc=%h want 0 0 00", HALTED, INSTR_READY, PC);
    end
  endtask

  task automatic test_reset_mid_exec();
    int n;
    reset_dut();
    n = 0;
    while (INSTR_READY !== 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    INSTRUCTION = 12'h5C3;
    INSTR_VALID = 1'b1;
    @(posedge CLK);
    #2;
    INSTR_VALID = 1'b0;
    n_cmp++;
    if (CE_ACC !== 1'b1) begin
      n_err++;
      $display("FAIL mid_exec_ce_acc: got %b want 1", CE_ACC);
    end
    RESET = 1'b1;
    #1;
    n_cmp++;
    if ({INSTR_READY, HALTED, SEL, CE_R, CE_ACC, OP, IMM, REG_IDX, PC} !==
        {1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'hA, 8'h00, 2'b00, 8'h00}) begin
      n_err++;
      $display("FAIL async_reset: rdy=%b h=%b sel=%b ce_r=%b ce=%b op=%h imm=%h idx=%h pc=%h",
               INSTR_READY, HALTED, SEL, CE_R, CE_ACC, OP, IMM, REG_IDX, PC);
    end
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic test_reg_range();
    logic [11:0] ins [2];
    logic [2:0]  want [2];
    logic [2:0]  e;
    int n;
    ins  = '{12'hB03, 12'hB02};
    want = '{3'b000, 3'b100};
    reset_dut();
    for (int i = 0; i < 2; i++) begin
      n = 0;
      while (ready3 !== 1'b1 && n < 20) begin
        @(negedge CLK);
        n++;
      end
      instr3 = ins[i];
      valid3 = 1'b1;
      sb3_q.push_back(want[i]);
      @(negedge CLK);
      valid3 = 1'b0;
      e = sb3_q.pop_front();
      n_cmp++;
      if ({ce_r3, ce_acc3, sel3, op3} !== {e, 1'b0, 1'b0, 4'hA}) begin
        n_err++;
        $display("FAIL nregs3_st%0d: ce_r=%b ce=%b sel=%b op=%h want ce_r=%b", i, ce_r3, ce_acc3, sel3, op3, e);
      end
    end
  endtask

  initial begin
    CLK         = 1'b0;
    RESET       = 1'b1;
    INSTRUCTION = 12'h000;
    INSTR_VALID = 1'b0;
    ZERO        = 1'b0;
    instr3      = 12'h000;
    valid3      = 1'b0;
    zero3       = 1'b0;
    pc_m        = 8'h00;
    test_reset();
    test_ldi_st();
    test_jz();
    test_wrap_stall();
    test_back_to_back();
    test_halt();
    test_reset_mid_exec();
    test_reg_range();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Parametrised, multi-cycle successor to the combinational opcode decoder. It owns the program counter and fetches instructions over a ready/valid handshake. Each instruction is held in an instruction register and drives one cycle of datapath strobes for an N-register file, the accumulator and the ALU. It adds immediate load, jumps, a zero-conditional jump and a halt state.

## Interface
Parameters:
- OP_WIDTH, 4: ALU operation code width.
- DATA_WIDTH, 8: operand/immediate field width; INSTRUCTION width is 4+DATA_WIDTH.
- NUM_REGS, 4: number of general registers, 1..2^DATA_WIDTH.
- REG_AW, 2: register index width, ≥ clog2(NUM_REGS).
- PC_WIDTH, 8: program counter width, ≤ DATA_WIDTH.

Ports:
- CLK  in  1  single clock; all state changes on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- INSTRUCTION  in  4+DATA_WIDTH  {opcode[3:0], field[DATA_WIDTH-1:0]} from program memory.
- INSTR_VALID  in  1  INSTRUCTION is valid for the address on PC.
- ZERO  in  1  ALU zero flag, sampled in EXEC.
- INSTR_READY  out  1  sequencer accepts an instruction this cycle.
- PC  out  PC_WIDTH  fetch address.
- SEL  out  1  accumulator input mux; 1 selects IMM.
- IMM  out  DATA_WIDTH  immediate, equal to field of the held instruction.
- CE_R  out  NUM_REGS  one-hot register write enable.
- REG_IDX  out  REG_AW  register read index, equal to field[REG_AW-1:0].
- CE_ACC  out  1  accumulator write enable.
- OP  out  OP_WIDTH  ALU operation.
- HALTED  out  1  sequencer is in the HALT state.

## Operation
- States: IDLE, FETCH, EXEC, HALT. Reset enters IDLE.
- IDLE lasts 1 cycle, then goes to FETCH.
- FETCH: INSTR_READY=1. On INSTR_VALID=1, latch INSTRUCTION into IR, set PC<=PC+1 (wraps 2^PC_WIDTH-1 to 0), and go to EXEC. Otherwise stay in FETCH.
- EXEC: lasts exactly 1 cycle and drives strobes decoded from IR. Returns to FETCH, except HLT, which goes to HALT.
- HALT: INSTR_READY=0, HALTED=1. Only RESET exits.
- Idle strobe set (every state except EXEC, and the NOP-like cases): SEL=0, CE_R=0, CE_ACC=0, OP=4'hA (pass accumulator).
- Opcodes, with their EXEC strobes. OP is zero-extended to OP_WIDTH.
  - 0–9 (NOT, XOR, OR, AND, SUB, ADD R, RR, RL, DEC, INC): CE_ACC=1, OP=opcode.
  - A, LD R: CE_ACC=1, OP=4'hB (pass register).
  - B, ST R: CE_R[idx]=1, OP=4'hA.
  - C, LDI: SEL=1, CE_ACC=1, OP=4'hA.
  - D, JMP: no strobes; PC<=field[PC_WIDTH-1:0].
  - E, JZ: no strobes; if ZERO=1, PC<=field[PC_WIDTH-1:0], else PC is unchanged.
  - F, HLT: no strobes; go to HALT.
- Register index idx=field[REG_AW-1:0]. If idx ≥ NUM_REGS, CE_R=0 and the instruction becomes a no-op, with CE_ACC still per its opcode.
- REG_IDX and IMM follow IR in every state.

## Timing
- Reset values: state=IDLE, PC=0, IR=0, INSTR_READY=0, HALTED=0, SEL=0, CE_R=0, CE_ACC=0, OP=4'hA, IMM=0, REG_IDX=0.
- Instruction accepted at edge t. EXEC strobes are valid for the cycle between edges t and t+1. INSTR_READY is high again at t+1.
- Peak throughput is 1 instruction per 2 cycles. The PC for the next fetch is valid from edge t (or t+1 for a jump).
- The jump target overrides the increment. PC after a taken jump is the target exactly, with no +1.
- ZERO is sampled only on the EXEC→FETCH edge.
- INSTR_VALID is ignored outside FETCH.
- RESET asserted in any state, mid-EXEC included, immediately forces all reset values. Strobes drop asynchronously.
- Outputs are decoded from registered state and IR only; there is no combinational path from INSTRUCTION or ZERO to any output.

## Test plan
- Reset release with INSTR_VALID=1: one cycle of INSTR_READY=0 (IDLE), then the fetch at PC=0. After the handshake PC=1, and the next cycle has CE_ACC=1 with OP per opcode.
- LDI 0x5A: in EXEC, SEL=1, CE_ACC=1, IMM=0x5A, OP=4'hA. Then ST R field=2: CE_R=4'b0100, CE_ACC=0.
- JZ 0x40 with ZERO=0: PC continues at 0x06 (fetched at 0x05). Repeated with ZERO=1: next fetch at PC=0x40.
- PC wrap: JMP 0xFF, then any instruction fetched at 0xFF leaves PC=0x00. INSTR_VALID held low for 5 cycles: stays in FETCH, idle strobes, PC stable.
- NUM_REGS=3, ST R idx=3: CE_R=0 and no other strobe. HLT: HALTED=1 and INSTR_READY=0 permanently until RESET, which returns to IDLE with PC=0.
- RESET pulsed during an EXEC of ADD: CE_ACC falls in the same cycle without waiting for a clock edge, and all outputs take their reset values.
